// File: rtl/cpu_seq_pkg.sv
// Shared types and defaults for the multi-cycle RISC control sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    DM_NONE  = 2'b00,
    DM_LOAD  = 2'b01,
    DM_STORE = 2'b10
  } dmctrl_t;

  localparam logic [31:0] DEFAULT_RESET_PC = '0;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd1;

  // Reserved encoding 2'b11 behaves as no memory access.
  function automatic logic is_mem_op(input logic [1:0] d);
    return (d == DM_LOAD) || (d == DM_STORE);
  endfunction

endpackage

// File: rtl/seq_pc_unit.sv
// Program counter with EXEC-time branch latch and WB-time next-PC selection.
module seq_pc_unit
  import cpu_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        latch,
  input  logic        taken,
  input  logic [31:0] target,
  input  logic        advance,
  output logic [31:0] pc
);

  logic        br_taken;
  logic [31:0] br_target;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else begin
      if (latch) begin
        br_taken  <= taken;
        br_target <= target;
      end
      if (advance) begin
        pc       <= br_taken ? br_target : pc + PC_STEP;
        br_taken <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns the PC and issues one-hot stage enables.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP     = DEFAULT_PC_STEP,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [1:0]  dmctrl,
  input  logic        reg_write,
  input  logic        halt_insn,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        if_en,
  output logic        id_en,
  output logic        ex_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_d;
  logic [7:0] wait_cnt;
  logic       mem_timeout;

  assign mem_timeout = (state == S_MEM) && !mem_ready && (wait_cnt == TO_LAST);

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = halt_insn ? S_HALT : S_EXEC;
      S_EXEC:   state_d = is_mem_op(dmctrl) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready)        state_d = S_WB;
        else if (mem_timeout) state_d = S_HALT;
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      if_en       <= 1'b0;
      id_en       <= 1'b0;
      ex_en       <= 1'b0;
      mem_en      <= 1'b0;
      wb_en       <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      instr_count <= '0;
      wait_cnt    <= '0;
    end else begin
      state    <= state_d;
      if_en    <= (state_d == S_FETCH);
      id_en    <= (state_d == S_DECODE);
      ex_en    <= (state_d == S_EXEC);
      mem_en   <= (state_d == S_MEM);
      wb_en    <= (state_d == S_WB) && reg_write;
      busy     <= !((state_d == S_IDLE) || (state_d == S_HALT));
      halted   <= (state_d == S_HALT);
      wait_cnt <= (state == S_MEM) ? wait_cnt + 8'd1 : '0;
      if (mem_timeout)
        fault <= 1'b1;
      if (state == S_WB)
        instr_count <= instr_count + 32'd1;
    end
  end

  seq_pc_unit #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .latch   (state == S_EXEC),
    .taken   (branch_taken),
    .target  (branch_target),
    .advance (state == S_WB),
    .pc      (pc)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run, reg_write, halt_insn, branch_taken, mem_ready;
  logic [1:0]  dmctrl;
  logic [31:0] branch_target;
  logic [31:0] pc, instr_count;
  logic        if_en, id_en, ex_en, mem_en, wb_en, busy, halted, fault;
  logic [4:0]  en;

  int pass_cnt = 0;
  int total    = 0;

  assign en = {if_en, id_en, ex_en, mem_en, wb_en};

  always #5 clk = ~clk;

  cpu_sequencer #(
    .RESET_PC    (32'd0),
    .PC_STEP     (32'd1),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .dmctrl        (dmctrl),
    .reg_write     (reg_write),
    .halt_insn     (halt_insn),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_ready     (mem_ready),
    .pc            (pc),
    .if_en         (if_en),
    .id_en         (id_en),
    .ex_en         (ex_en),
    .mem_en        (mem_en),
    .wb_en         (wb_en),
    .busy          (busy),
    .halted        (halted),
    .fault         (fault),
    .instr_count   (instr_count)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    run = 0; dmctrl = 2'b00; reg_write = 1; halt_insn = 0;
    branch_taken = 0; branch_target = '0; mem_ready = 0;
    rst_n = 0;
    step(); step();
    rst_n = 1;
    total++; if (pc !== 32'd0) $display("FAIL reset_pc got %h want %h", pc, 32'd0); else pass_cnt++;
    total++; if (en !== 5'b00000) $display("FAIL reset_en got %b want %b", en, 5'b00000); else pass_cnt++;
    total++; if ({busy, halted, fault} !== 3'b000) $display("FAIL reset_flags got %b want %b", {busy, halted, fault}, 3'b000); else pass_cnt++;
    total++; if (instr_count !== 32'd0) $display("FAIL reset_count got %0d want %0d", instr_count, 0); else pass_cnt++;
    step();
    total++; if (en !== 5'b00000 || busy !== 1'b0) $display("FAIL idle_hold got en=%b busy=%b want en=00000 busy=0", en, busy); else pass_cnt++;
  endtask

  task automatic test_sequential();
    run = 1; mem_ready = 1;  // mem_ready must be ignored outside MEM
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (en !== 5'b10000 || pc !== 32'(i)) $display("FAIL seq_fetch%0d got en=%b pc=%h want en=10000 pc=%h", i, en, pc, 32'(i)); else pass_cnt++;
      step();
      total++; if (en !== 5'b01000) $display("FAIL seq_decode%0d got %b want %b", i, en, 5'b01000); else pass_cnt++;
      step();
      total++; if (en !== 5'b00100) $display("FAIL seq_exec%0d got %b want %b", i, en, 5'b00100); else pass_cnt++;
      step();
      total++; if (en !== 5'b00001 || busy !== 1'b1) $display("FAIL seq_wb%0d got en=%b busy=%b want en=00001 busy=1", i, en, busy); else pass_cnt++;
      if (i == 2) run = 0;
    end
    mem_ready = 0;
    step();
    total++; if (en !== 5'b00000 || busy !== 1'b0) $display("FAIL seq_idle got en=%b busy=%b want en=00000 busy=0", en, busy); else pass_cnt++;
    total++; if (pc !== 32'd3) $display("FAIL seq_pc got %h want %h", pc, 32'd3); else pass_cnt++;
    total++; if (instr_count !== 32'd3) $display("FAIL seq_count got %0d want %0d", instr_count, 3); else pass_cnt++;
  endtask

  task automatic test_load();
    int busy_cycles = 0, mem_cycles = 0, wb_cycles = 0;
    logic last_was_mem = 0, wb_after_mem = 0;
    dmctrl = 2'b01; run = 1; mem_ready = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (busy) busy_cycles++;
      if (wb_en) begin
        wb_cycles++;
        wb_after_mem = last_was_mem;
        run = 0;
        mem_ready = 0;
      end
      last_was_mem = mem_en;
      if (mem_en) begin
        mem_cycles++;
        mem_ready = (mem_cycles == 4);
      end
      if (!busy && c > 0) break;
    end
    dmctrl = 2'b00;
    total++; if (mem_cycles !== 4) $display("FAIL load_mem_cycles got %0d want %0d", mem_cycles, 4); else pass_cnt++;
    total++; if (busy_cycles !== 8) $display("FAIL load_latency got %0d want %0d", busy_cycles, 8); else pass_cnt++;
    total++; if (wb_cycles !== 1 || wb_after_mem !== 1'b1) $display("FAIL load_wb got cycles=%0d after_mem=%b want 1/1", wb_cycles, wb_after_mem); else pass_cnt++;
    total++; if (pc !== 32'd4 || instr_count !== 32'd4) $display("FAIL load_pc_count got pc=%h cnt=%0d want pc=4 cnt=4", pc, instr_count); else pass_cnt++;
  endtask

  task automatic test_branch();
    run = 1; branch_taken = 1; branch_target = 32'h40;
    step();
    total++; if (pc !== 32'd4) $display("FAIL br_fetch_pc got %h want %h", pc, 32'd4); else pass_cnt++;
    step(); step(); step();
    // Branch already latched in EXEC; scramble inputs to prove it.
    branch_taken = 0; branch_target = 32'h1234;
    step();
    total++; if (pc !== 32'h40 || en !== 5'b10000) $display("FAIL br_target got pc=%h en=%b want pc=40 en=10000", pc, en); else pass_cnt++;
    total++; if (instr_count !== 32'd5) $display("FAIL br_count got %0d want %0d", instr_count, 5); else pass_cnt++;
    step(); step(); step();
    run = 0;
    step();
    total++; if (pc !== 32'h41 || instr_count !== 32'd6) $display("FAIL br_notaken got pc=%h cnt=%0d want pc=41 cnt=6", pc, instr_count); else pass_cnt++;
  endtask

  task automatic test_halt();
    do_reset();
    run = 1; branch_taken = 1; branch_target = 32'd5;
    step(); step(); step(); step();
    branch_taken = 0;
    step();
    total++; if (pc !== 32'd5 || en !== 5'b10000) $display("FAIL halt_setup got pc=%h en=%b want pc=5 en=10000", pc, en); else pass_cnt++;
    halt_insn = 1;
    step();
    step();
    total++; if (halted !== 1'b1 || busy !== 1'b0 || en !== 5'b00000) $display("FAIL halt_state got halted=%b busy=%b en=%b want 1/0/00000", halted, busy, en); else pass_cnt++;
    total++; if (pc !== 32'd5 || instr_count !== 32'd1) $display("FAIL halt_pc_count got pc=%h cnt=%0d want pc=5 cnt=1", pc, instr_count); else pass_cnt++;
    halt_insn = 0;
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      step();
    end
    total++; if (halted !== 1'b1 || en !== 5'b00000 || pc !== 32'd5) $display("FAIL halt_sticky got halted=%b en=%b pc=%h want 1/00000/5", halted, en, pc); else pass_cnt++;
    run = 0;
    do_reset();
    total++; if (halted !== 1'b0 || pc !== 32'd0 || busy !== 1'b0) $display("FAIL halt_reset got halted=%b pc=%h busy=%b want 0/0/0", halted, pc, busy); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int mem_cycles = 0, wb_seen = 0;
    dmctrl = 2'b10; run = 1; mem_ready = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (mem_en) mem_cycles++;
      if (wb_en) wb_seen++;
      if (halted) break;
    end
    run = 0; dmctrl = 2'b00;
    total++; if (mem_cycles !== 15) $display("FAIL to_mem_cycles got %0d want %0d", mem_cycles, 15); else pass_cnt++;
    total++; if (halted !== 1'b1 || fault !== 1'b1) $display("FAIL to_fault got halted=%b fault=%b want 1/1", halted, fault); else pass_cnt++;
    total++; if (wb_seen !== 0 || instr_count !== 32'd0 || pc !== 32'd0) $display("FAIL to_nowb got wb=%0d cnt=%0d pc=%h want 0/0/0", wb_seen, instr_count, pc); else pass_cnt++;
    do_reset();
    total++; if (fault !== 1'b0 || halted !== 1'b0) $display("FAIL to_reset got fault=%b halted=%b want 0/0", fault, halted); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    dmctrl = 2'b01; run = 1; mem_ready = 0;
    step(); step(); step(); step(); step();
    total++; if (en !== 5'b00010) $display("FAIL midmem_en got %b want %b", en, 5'b00010); else pass_cnt++;
    rst_n = 0;
    step();
    rst_n = 1; run = 0; dmctrl = 2'b00;
    total++; if (en !== 5'b00000 || {busy, halted, fault} !== 3'b000 || pc !== 32'd0 || instr_count !== 32'd0)
      $display("FAIL midmem_reset got en=%b flags=%b pc=%h cnt=%0d want 00000/000/0/0", en, {busy, halted, fault}, pc, instr_count); else pass_cnt++;
    step();
    run = 1; branch_taken = 1; branch_target = 32'hFFFF_FFFF;
    step(); step(); step(); step();
    branch_taken = 0; branch_target = '0;
    step();
    total++; if (pc !== 32'hFFFF_FFFF) $display("FAIL wrap_setup got %h want %h", pc, 32'hFFFF_FFFF); else pass_cnt++;
    step(); step(); step();
    step();
    total++; if (pc !== 32'h0000_0000 || en !== 5'b10000 || instr_count !== 32'd2) $display("FAIL wrap_pc got pc=%h en=%b cnt=%0d want 0/10000/2", pc, en, instr_count); else pass_cnt++;
    run = 0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_load();
    test_branch();
    test_halt();
    test_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer for the RISC core.
- Owns the program counter and steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB by issuing one-hot stage enables to IMem, IDecode, ALU, DMem and RegisterFile.
- Replaces the free-running external pc/clk stimulus.
- Handles branch redirect, data-memory wait handshake with timeout, halt, and instruction counting.

Parameters:
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, sequential PC increment (word-addressed instruction memory).
- MEM_TIMEOUT, 15, maximum cycles in MEM waiting for mem_ready before a fault (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- run  in  1  level; high allows instruction issue.
- dmctrl  in  2  decoder memory op, valid in DECODE and later: 00 none, 01 load, 10 store, 11 reserved (treated as none).
- reg_write  in  1  decoder says the instruction writes a register.
- halt_insn  in  1  decoder flags a halt instruction.
- branch_taken  in  1  ALU branch resolution, sampled in EXEC.
- branch_target  in  32  redirect address, sampled in EXEC.
- mem_ready  in  1  DMem completion handshake.
- pc  out  32  current instruction address to IMem.
- if_en, id_en, ex_en, mem_en  out  1 each  stage enables.
- wb_en  out  1  RegisterFile write enable (drives regctrl).
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.
- fault  out  1  sticky memory-timeout flag.
- instr_count  out  32  retired instruction count.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State IDLE, pc=RESET_PC, all enables 0, busy/halted/fault 0, instr_count 0, wait counter 0, latched branch 0.
  - Takes priority over everything, including mid-MEM and HALT.
- States and transitions:
  - IDLE: goes to FETCH when run=1; otherwise stays.
  - FETCH: if_en=1 for 1 cycle, then DECODE.
  - DECODE: id_en=1. halt_insn=1 goes to HALT (pc unchanged, instruction not counted). Otherwise EXEC.
  - EXEC: ex_en=1. Latch branch_taken and branch_target. Go to MEM if dmctrl is 01 or 10, else WB.
  - MEM: mem_en held 1 until mem_ready=1. Leave on the cycle mem_ready is sampled high, then WB.
    - Wait counter counts MEM cycles.
    - If MEM_TIMEOUT cycles elapse without mem_ready, go to HALT with fault=1 and no write-back.
    - mem_ready is ignored outside MEM.
  - WB: wb_en=reg_write for 1 cycle.
    - At exit, pc becomes the latched target if the branch was taken, else pc+PC_STEP, modulo 2^32 (0xFFFFFFFF+1 wraps to 0).
    - instr_count increments, wrapping modulo 2^32.
    - Next state is FETCH if run=1, else IDLE.
  - HALT: all enables 0, halted=1. Exits only via reset.
- Latency:
  - Non-memory instruction: 4 cycles.
  - Memory instruction: 5 cycles with zero wait, plus one cycle per low mem_ready cycle.
- run deasserted mid-instruction: the current instruction completes through WB, then the block goes to IDLE. run is not sampled elsewhere.
- Exactly one enable is high per cycle, except in IDLE and HALT where none is high.
- Outputs are registered: enables reflect the current state; pc updates coincident with entering FETCH.

Decomposition:
- Shared package cpu_seq_pkg holds:
  - State enumeration (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT).
  - dmctrl encodings (DM_NONE, DM_LOAD, DM_STORE).
  - Default RESET_PC and PC_STEP constants.
- One sub-module, seq_pc_unit: PC register, branch latch and next-PC mux, with load/advance inputs from the FSM.

Test Plan:
- Reset then run=1 with three non-branch, non-memory instructions (reg_write=1) -> pc 0,1,2,3 at each FETCH; wb_en pulses every 4th cycle; instr_count=3; if_en/id_en/ex_en/wb_en observed in order.
- Load (dmctrl=01) with mem_ready low for 3 cycles -> mem_en high for 4 cycles, wb_en one cycle after mem_ready, total instruction latency 8 cycles.
- Branch with branch_taken=1, target 0x40 at EXEC -> next FETCH has pc=0x40; instr_count increments by 1; no-branch case advances by PC_STEP.
- halt_insn=1 at DECODE with pc=5 -> HALT next cycle, halted=1, pc stays 5, instr_count unchanged, run toggling has no effect; rst_n=0 returns to IDLE with pc=0.
- Store with mem_ready held low -> after 15 MEM cycles state is HALT, fault=1, wb_en never asserted; reset clears fault.
- rst_n=0 during MEM and pc=0xFFFFFFFF wrap case -> reset forces IDLE with all outputs at reset values next edge; a non-branch instruction at 0xFFFFFFFF fetches 0x00000000 next.
